sccb_target: RTL

SCCB target (camera-side responder) that decodes SIOC/SIOD traffic from an SCCB initiator and serves register reads and writes from an internal byte register file. It uses 16-bit sub-addresses with 3-phase writes and 2-phase read sequences. It is the bench and emulation counterpart of the OV5642 init sequencer's SCCB master. It also exports a write strobe so emulated sensor logic can react to configuration writes.

---
 rtl/sccb_target_if.sv | 37 +++
 rtl/sccb_target.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target_if.sv
// sccb_target_if: SCCB pad pair plus the configuration-write strobe bundle.
// Latency: none, wires only.
// Backpressure: none; the initiator owns SIOC and the target only answers on SIOD.
interface sccb_target_if;
   logic        i_sioc;
   logic        i_siod_in;
   logic        o_siod_out;
   logic        o_siod_oe;
   logic        o_busy;
   logic        o_wr_strobe;
   logic [15:0] o_wr_addr;
   logic [7:0]  o_wr_data;

   // Target side: samples the bus, drives SIOD and the write strobe.
   modport slave (
      input  i_sioc,
      input  i_siod_in,
      output o_siod_out,
      output o_siod_oe,
      output o_busy,
      output o_wr_strobe,
      output o_wr_addr,
      output o_wr_data
   );

   // Initiator / bench side.
   modport master (
      output i_sioc,
      output i_siod_in,
      input  o_siod_out,
      input  o_siod_oe,
      input  o_busy,
      input  o_wr_strobe,
      input  o_wr_addr,
      input  o_wr_data
   );
endinterface

// File: rtl/sccb_target.sv
// sccb_target: SCCB camera-side target, 16-bit sub-address, 2**ADDR_W byte register file, write strobe.
// Latency: 3 clk pad->edge pulse, SIOD drive 4 clk after SIOC pad fall (+2 each with SCCB_TARGET_GLITCH_FILT_EN).
// Backpressure: none; initiator paces SIOC, target always acks its own ID, addresses and write data.
module sccb_target #(
   parameter logic [7:0]  DEV_ID = 8'h78,
   parameter int unsigned ADDR_W = 6
) (
   input  logic         i_clk,
   input  logic         i_rst,
   sccb_target_if.slave io_bus
);
   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [7:0]  RD_ID = DEV_ID | 8'h01;

   typedef enum logic [3:0] {
      ST_IDLE, ST_ID, ST_ID_ACK, ST_ADDR_HI, ST_ADDR_HI_ACK, ST_ADDR_LO,
      ST_ADDR_LO_ACK, ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_scl_sync, r_sda_sync;
   logic        r_scl_line, r_sda_line, r_scl_prev, r_sda_prev;
   logic        w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall, w_start, w_stop;

   logic [3:0]  r_bitcnt, w_bitcnt_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic [7:0]  r_tx, w_tx_nxt;
   logic [15:0] r_ptr, w_ptr_nxt;
   logic [7:0]  r_addr_hi, w_addr_hi_nxt;
   logic        r_rd_nack, w_rd_nack_nxt;
   logic        r_oe, w_oe_nxt, r_out, w_out_nxt, r_busy, w_busy_nxt;
   logic        r_wr_strobe, w_wr_strobe_nxt;
   logic [15:0] r_wr_addr, w_wr_addr_nxt;
   logic [7:0]  r_wr_data, w_wr_data_nxt;
   logic [7:0]  r_mem [DEPTH];

   logic        w_mem_we, w_cur_ok, w_inc_ok;
   logic [7:0]  w_rx_byte, w_rd_cur, w_rd_inc;
   logic [15:0] w_ptr_inc;

   // Two-flop synchronizers; lines idle high so reset to 1 to avoid false edges.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
      end else begin
         r_scl_sync <= {r_scl_sync[0], io_bus.i_sioc};
         r_sda_sync <= {r_sda_sync[0], io_bus.i_siod_in};
      end
   end

`ifdef SCCB_TARGET_GLITCH_FILT_EN
   logic [1:0] r_scl_hist, r_sda_hist;

   // Line follows the synchronizer only after three consecutive equal samples.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_scl_hist <= 2'b11;
         r_sda_hist <= 2'b11;
         r_scl_line <= 1'b1;
         r_sda_line <= 1'b1;
      end else begin
         r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
         r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
         if (r_scl_sync[1] == r_scl_hist[0] && r_scl_hist[0] == r_scl_hist[1])
            r_scl_line <= r_scl_sync[1];
         if (r_sda_sync[1] == r_sda_hist[0] && r_sda_hist[0] == r_sda_hist[1])
            r_sda_line <= r_sda_sync[1];
      end
   end
`else
   // Unfiltered: line register is the first stage of the edge detector.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_scl_line <= 1'b1;
         r_sda_line <= 1'b1;
      end else begin
         r_scl_line <= r_scl_sync[1];
         r_sda_line <= r_sda_sync[1];
      end
   end
`endif

   // Previous line values for the edge detector.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_scl_prev <= 1'b1;
         r_sda_prev <= 1'b1;
      end else begin
         r_scl_prev <= r_scl_line;
         r_sda_prev <= r_sda_line;
      end
   end

   assign w_scl_rise = r_scl_line & ~r_scl_prev;
   assign w_scl_fall = ~r_scl_line & r_scl_prev;
   assign w_sda_rise = r_sda_line & ~r_sda_prev;
   assign w_sda_fall = ~r_sda_line & r_sda_prev;
   // SIOC must be steadily high across the SIOD transition.
   assign w_start    = w_sda_fall & r_scl_line & r_scl_prev;
   assign w_stop     = w_sda_rise & r_scl_line & r_scl_prev;

   assign w_rx_byte  = {r_shift[6:0], r_sda_line};
   assign w_ptr_inc  = r_ptr + 16'd1;
   assign w_cur_ok   = (r_ptr >> ADDR_W) == 16'd0;
   assign w_inc_ok   = (w_ptr_inc >> ADDR_W) == 16'd0;
   assign w_rd_cur   = w_cur_ok ? r_mem[r_ptr[ADDR_W-1:0]] : 8'h00;
   assign w_rd_inc   = w_inc_ok ? r_mem[w_ptr_inc[ADDR_W-1:0]] : 8'h00;

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and datapath: sample on scl_rise, change SIOD only on scl_fall.
   always_comb begin
      w_state_nxt     = r_state;
      w_bitcnt_nxt    = r_bitcnt;
      w_shift_nxt     = r_shift;
      w_tx_nxt        = r_tx;
      w_ptr_nxt       = r_ptr;
      w_addr_hi_nxt   = r_addr_hi;
      w_rd_nack_nxt   = r_rd_nack;
      w_oe_nxt        = r_oe;
      w_out_nxt       = r_out;
      w_busy_nxt      = r_busy;
      w_wr_strobe_nxt = 1'b0;
      w_wr_addr_nxt   = r_wr_addr;
      w_wr_data_nxt   = r_wr_data;
      w_mem_we        = 1'b0;

      if (w_stop) begin
         w_state_nxt = ST_IDLE;
         w_oe_nxt    = 1'b0;
         w_out_nxt   = 1'b1;
         w_busy_nxt  = 1'b0;
      end else if (w_start) begin
         w_state_nxt  = ST_ID;
         w_bitcnt_nxt = 4'd0;
         w_oe_nxt     = 1'b0;
         w_out_nxt    = 1'b1;
         w_busy_nxt   = 1'b1;
      end else begin
         case (r_state)
            ST_ID, ST_ADDR_HI, ST_ADDR_LO, ST_WDATA: begin
               if (w_scl_rise && r_bitcnt != 4'd8) begin
                  w_shift_nxt  = w_rx_byte;
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
                  // Last data bit: commit the write now so the strobe leads the ACK.
                  if (r_state == ST_WDATA && r_bitcnt == 4'd7) begin
                     w_ptr_nxt = w_ptr_inc;
                     if (w_cur_ok) begin
                        w_mem_we        = 1'b1;
                        w_wr_strobe_nxt = 1'b1;
                        w_wr_addr_nxt   = r_ptr;
                        w_wr_data_nxt   = w_rx_byte;
                     end
                  end
               end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                  w_bitcnt_nxt = 4'd0;
                  w_oe_nxt     = 1'b1;
                  w_out_nxt    = 1'b0;
                  case (r_state)
                     ST_ID: begin
                        if (r_shift == DEV_ID || r_shift == RD_ID) begin
                           w_state_nxt = ST_ID_ACK;
                        end else begin
                           w_state_nxt = ST_IGNORE;
                           w_oe_nxt    = 1'b0;
                           w_out_nxt   = 1'b1;
                        end
                     end
                     ST_ADDR_HI: begin
                        w_addr_hi_nxt = r_shift;
                        w_state_nxt   = ST_ADDR_HI_ACK;
                     end
                     ST_ADDR_LO: begin
                        w_ptr_nxt   = {r_addr_hi, r_shift};
                        w_state_nxt = ST_ADDR_LO_ACK;
                     end
                     default: w_state_nxt = ST_WDATA_ACK;
                  endcase
               end
            end
            ST_ID_ACK, ST_ADDR_HI_ACK, ST_ADDR_LO_ACK, ST_WDATA_ACK: begin
               if (w_scl_fall) begin
                  w_oe_nxt     = 1'b0;
                  w_out_nxt    = 1'b1;
                  w_bitcnt_nxt = 4'd0;
                  case (r_state)
                     ST_ID_ACK: begin
                        if (r_shift == RD_ID) begin
                           // Read: first data bit goes out on the fall ending the ACK.
                           w_state_nxt = ST_RDATA;
                           w_oe_nxt    = 1'b1;
                           w_out_nxt   = w_rd_cur[7];
                           w_tx_nxt    = {w_rd_cur[6:0], 1'b0};
                        end else begin
                           w_state_nxt = ST_ADDR_HI;
                        end
                     end
                     ST_ADDR_HI_ACK: w_state_nxt = ST_ADDR_LO;
                     default:        w_state_nxt = ST_WDATA;
                  endcase
               end
            end
            ST_RDATA: begin
               if (w_scl_fall) begin
                  if (r_bitcnt == 4'd7) begin
                     w_state_nxt  = ST_RDATA_ACK;
                     w_oe_nxt     = 1'b0;
                     w_out_nxt    = 1'b1;
                     w_bitcnt_nxt = 4'd0;
                  end else begin
                     w_out_nxt    = r_tx[7];
                     w_tx_nxt     = {r_tx[6:0], 1'b0};
                     w_bitcnt_nxt = r_bitcnt + 4'd1;
                  end
               end
            end
            ST_RDATA_ACK: begin
               if (w_scl_rise) begin
                  w_rd_nack_nxt = r_sda_line;
               end else if (w_scl_fall) begin
                  if (!r_rd_nack) begin
                     w_ptr_nxt   = w_ptr_inc;
                     w_state_nxt = ST_RDATA;
                     w_oe_nxt    = 1'b1;
                     w_out_nxt   = w_rd_inc[7];
                     w_tx_nxt    = {w_rd_inc[6:0], 1'b0};
                  end else begin
                     w_state_nxt = ST_IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bitcnt    <= 4'd0;
         r_shift     <= 8'h00;
         r_tx        <= 8'h00;
         r_ptr       <= 16'h0000;
         r_addr_hi   <= 8'h00;
         r_rd_nack   <= 1'b1;
         r_oe        <= 1'b0;
         r_out       <= 1'b1;
         r_busy      <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= 16'h0000;
         r_wr_data   <= 8'h00;
      end else begin
         r_bitcnt    <= w_bitcnt_nxt;
         r_shift     <= w_shift_nxt;
         r_tx        <= w_tx_nxt;
         r_ptr       <= w_ptr_nxt;
         r_addr_hi   <= w_addr_hi_nxt;
         r_rd_nack   <= w_rd_nack_nxt;
         r_oe        <= w_oe_nxt;
         r_out       <= w_out_nxt;
         r_busy      <= w_busy_nxt;
         r_wr_strobe <= w_wr_strobe_nxt;
         r_wr_addr   <= w_wr_addr_nxt;
         r_wr_data   <= w_wr_data_nxt;
      end
   end

   // Register file, cleared on reset, written at the rise sampling data bit 0.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      end else if (w_mem_we) begin
         r_mem[r_ptr[ADDR_W-1:0]] <= w_rx_byte;
      end
   end

   assign io_bus.o_siod_oe   = r_oe;
   assign io_bus.o_siod_out  = r_out;
   assign io_bus.o_busy      = r_busy;
   assign io_bus.o_wr_strobe = r_wr_strobe;
   assign io_bus.o_wr_addr   = r_wr_addr;
   assign io_bus.o_wr_data   = r_wr_data;
endmodule
